// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared R-type function codes and HI/LO mul/div state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam int ITER_CYCLES = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One combinational restoring-division step.
// Revision : 1.0 - initial release
// ============================================================================
module div_step (
  input  logic [32:0] part_rem,
  input  logic [31:0] divisor,
  output logic [31:0] next_rem,
  output logic        q_bit
);

  logic [31:0] w_diff;

  // The true difference is always below the divisor, so 32 bits suffice.
  assign w_diff   = part_rem[31:0] - divisor;
  assign q_bit    = (part_rem >= {1'b0, divisor});
  assign next_rem = q_bit ? w_diff : part_rem[31:0];

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative HI/LO multiply/divide unit. Define MULDIV_FAST_MULT_EN
//            for single-cycle MULT/MULTU.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  fncode,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result
);

  localparam logic [4:0] c_last_cnt = 5'(ITER_CYCLES - 1);

  muldiv_state_t r_state, w_next;
  logic [4:0]    r_cnt;
  logic [31:0]   r_b, r_wh, r_wl, r_hi, r_lo;
  logic          r_is_div, r_neg_lo, r_neg_hi, r_done;
  logic          w_idle, w_accept, w_signed, w_div, w_start_iter, w_qbit;
  logic [31:0]   w_abs_a, w_abs_b, w_rem;
  logic [32:0]   w_sum;
  logic [63:0]   w_fix_prod;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = start && w_idle && is_muldiv(fncode);
  assign w_signed = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);
  assign w_div    = (fncode == FUNCT_DIV) || (fncode == FUNCT_DIVU);
  assign w_abs_a  = (w_signed && op_a[31]) ? -op_a : op_a;
  assign w_abs_b  = (w_signed && op_b[31]) ? -op_b : op_b;

`ifdef MULDIV_FAST_MULT_EN
  logic        w_fast;
  logic [63:0] w_fast_prod;
  assign w_fast       = w_accept && !w_div;
  assign w_start_iter = w_accept && w_div;
  assign w_fast_prod  = {{32{w_signed & op_a[31]}}, op_a} *
                        {{32{w_signed & op_b[31]}}, op_b};
`else
  assign w_start_iter = w_accept;
`endif

  // Multiply: r_wl holds the multiplier shifting out, r_wh the running sum.
  assign w_sum      = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_b} : 33'd0);
  assign w_fix_prod = r_neg_lo ? -{r_wh, r_wl} : {r_wh, r_wl};

  // Divide: r_wh is the partial remainder, r_wl shifts dividend out / quotient in.
  div_step u_div_step (
    .part_rem ({r_wh, r_wl[31]}),
    .divisor  (r_b),
    .next_rem (w_rem),
    .q_bit    (w_qbit)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_iter) w_next = ITER;
      ITER:    if (r_cnt == c_last_cnt) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 5'd0;
      r_b      <= 32'd0;
      r_wh     <= 32'd0;
      r_wl     <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_iter) begin
        r_cnt    <= 5'd0;
        r_b      <= w_abs_b;
        r_wh     <= 32'd0;
        r_wl     <= w_abs_a;
        r_is_div <= w_div;
        // Divide by zero keeps the raw all-ones quotient.
        r_neg_lo <= w_signed && (op_a[31] ^ op_b[31]) && !(w_div && (op_b == 32'd0));
        r_neg_hi <= w_signed && op_a[31];
      end else if (r_state == ITER) begin
        r_cnt <= r_cnt + 5'd1;
        if (r_is_div) begin
          r_wh <= w_rem;
          r_wl <= {r_wl[30:0], w_qbit};
        end else begin
          {r_wh, r_wl} <= {w_sum, r_wl[31:1]};
        end
      end else if (r_state == FIX) begin
        r_done <= 1'b1;
        if (r_is_div) begin
          r_lo <= r_neg_lo ? -r_wl : r_wl;
          r_hi <= r_neg_hi ? -r_wh : r_wh;
        end else begin
          {r_hi, r_lo} <= w_fix_prod;
        end
      end
      if (start && w_idle) begin
        if (fncode == FUNCT_MTHI) r_hi <= op_a;
        if (fncode == FUNCT_MTLO) r_lo <= op_a;
      end
`ifdef MULDIV_FAST_MULT_EN
      if (w_fast) begin
        {r_hi, r_lo} <= w_fast_prod;
        r_done       <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    result = 32'd0;
    if (fncode == FUNCT_MFHI)      result = r_hi;
    else if (fncode == FUNCT_MFLO) result = r_lo;
  end

  assign busy = !w_idle;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Scoreboard bench for muldiv_unit (honours MULDIV_FAST_MULT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  fncode = FUNCT_MFHI;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo, result;

  muldiv_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .fncode (fncode),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   busy_total = 0;
  int   snap = 0;

  always @(negedge clk) if (busy) busy_total++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    fncode = fn;
    op_a   = a;
    op_b   = b;
    tick();
    start  = 1'b0;
  endtask

  function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb64;
    logic signed [31:0] q, rm;
    logic [63:0] r;
    r = 64'd0;
    sa = $signed(a);
    sb64 = $signed(b);
    if (fn == FUNCT_MULT) r = sa * sb64;
    else if (fn == FUNCT_MULTU) r = {32'd0, a} * {32'd0, b};
    else if (fn == FUNCT_DIV) begin
      if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
      else begin
        q  = $signed(a) / $signed(b);
        rm = $signed(a) % $signed(b);
        r  = {rm, q};
      end
    end else if (fn == FUNCT_DIVU) begin
      if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
      else r = {a % b, a / b};
    end
    return r;
  endfunction

  function automatic int exp_busy(input logic [5:0] fn);
`ifdef MULDIV_FAST_MULT_EN
    if (fn == FUNCT_MULT || fn == FUNCT_MULTU) return 0;
`endif
    return (fn == 6'h3F) ? 0 : 33;
  endfunction

  task automatic finish_op(input int nbusy);
    int   k;
    exp_t e;
    k = 0;
    while (!done && k < 200) begin
      tick();
      k++;
    end
    if (!done) begin
      chk("done_timeout", {31'd0, done}, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk("sb_empty_on_done", {31'd0, done}, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_hi"}, hi, e.hi);
      chk({e.tag, "_lo"}, lo, e.lo);
      chk({e.tag, "_busycyc"}, 32'(busy_total - snap), 32'(nbusy));
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    sb.push_back('{tag, eh, el});
    snap = busy_total;
    issue(fn, a, b);
    finish_op(exp_busy(fn));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m;
    logic [5:0]  fn;
    logic [31:0] a, b;

    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    run_op("mult_neg", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", FUNCT_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("div_zero_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    issue(FUNCT_MTLO, 32'h1234, 32'd0);
    fncode = FUNCT_MFLO;
    #1 chk("mflo", result, 32'h1234);
    issue(FUNCT_MTHI, 32'hABCD, 32'd0);
    fncode = FUNCT_MFHI;
    #1 chk("mfhi", result, 32'hABCD);
    fncode = FUNCT_DIV;
    #1 chk("result_other", result, 32'd0);
    issue(FUNCT_MFHI, 32'h5555, 32'd0);
    chk("mfhi_start_hi", hi, 32'hABCD);
    chk("mfhi_start_busy", {31'd0, busy}, 32'd0);

    sb.push_back('{"divu_10_3", 32'd1, 32'd3});
    snap = busy_total;
    issue(FUNCT_DIVU, 32'd10, 32'd3);
    repeat (3) tick();
    issue(FUNCT_MTHI, 32'hDEAD, 32'd0);
    chk("mthi_busy_hi", hi, 32'hABCD);
    chk("busy_lo_stable", lo, 32'h1234);
    issue(FUNCT_MULTU, 32'd5, 32'd5);
    finish_op(33);
    run_op("b2b_multu", FUNCT_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    issue(FUNCT_MTHI, 32'd77, 32'd0);
    issue(FUNCT_DIV, 32'd1000, 32'd7);
    repeat (9) tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    #1 reset = 1'b0;
    tick();
    run_op("after_rst", FUNCT_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142);

    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       fn = FUNCT_MULT;
        1:       fn = FUNCT_MULTU;
        2:       fn = FUNCT_DIV;
        default: fn = FUNCT_DIVU;
      endcase
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      if (i % 3 == 0) b = -b;
      m = model(fn, a, b);
      run_op("rand", fn, a, b, m[63:32], m[31:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
